// File: rtl/sevenseg_scan_decoder.sv
// Rebuilds the 16-bit word shown on a four-digit multiplexed seven-segment display.
// It debounces the scan, decodes each digit and reports every complete frame.
module sevenseg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  err_mask,
  output logic        stalled
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic          SETTLE_ONE  = (SETTLE_CYCLES == 1);

  typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

  state_t        state;
  logic [3:0]    an_q, an_p;
  logic [6:0]    seg_q, seg_p;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    cap;
  logic [3:0]    fbuf [4];
  logic [3:0]    ebuf;

  logic          valid;
  logic [1:0]    idx;
  logic          same;
  logic          accept;
  logic          done;
  logic          timeout_hit;
  logic [3:0]    cap_nxt;
  logic [4:0]    dec;
  logic [CW-1:0] cnt_inc;

  // Active-low segments to {error, nibble}; anything off the hex table is an error.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (~s)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h4E:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Sample qualification: exactly one anode low, and comparison with the prior sample.
  always_comb begin
    valid = 1'b1;
    idx   = 2'd0;
    case (an_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: valid = 1'b0;
    endcase
    same    = (an_q == an_p) && (seg_q == seg_p);
    dec     = decode(seg_q);
    cnt_inc = cnt + CW'(1);
  end

  // Acceptance, frame completion and timeout decisions for this edge.
  always_comb begin
    accept = 1'b0;
    case (state)
      S_WAIT:   accept = valid && SETTLE_ONE;
      S_SETTLE: accept = valid && same && (cnt_inc == SETTLE_MAX);
      S_HOLD:   accept = valid && !same && SETTLE_ONE;
      default:  accept = 1'b0;
    endcase
    done        = (cap == 4'hF);
    timeout_hit = !accept && (tcnt != TIMEOUT_MAX) && ((tcnt + TW'(1)) == TIMEOUT_MAX);
    cap_nxt     = cap;
    if (done || timeout_hit) cap_nxt = 4'h0;
    if (accept) cap_nxt = cap_nxt | ~an_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      an_q        <= 4'h0;
      an_p        <= 4'h0;
      seg_q       <= 7'h00;
      seg_p       <= 7'h00;
      cnt         <= '0;
      tcnt        <= '0;
      cap         <= 4'h0;
      ebuf        <= 4'h0;
      for (int i = 0; i < 4; i++) fbuf[i] <= 4'h0;
      value       <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_mask    <= 4'h0;
      stalled     <= 1'b0;
    end else begin
      an_q        <= an;
      seg_q       <= seg;
      an_p        <= an_q;
      seg_p       <= seg_q;
      frame_valid <= 1'b0;

      // Scan debounce FSM
      case (state)
        S_WAIT: begin
          if (valid) begin
            if (SETTLE_ONE) begin
              state <= S_HOLD;
            end else begin
              state <= S_SETTLE;
              cnt   <= CW'(1);
            end
          end
        end
        S_SETTLE: begin
          if (!valid)      state <= S_WAIT;
          else if (!same)  cnt   <= CW'(1);
          else if (accept) state <= S_HOLD;
          else             cnt   <= cnt_inc;
        end
        S_HOLD: begin
          if (!same) begin
            if (!valid) begin
              state <= S_WAIT;
            end else if (!SETTLE_ONE) begin
              state <= S_SETTLE;
              cnt   <= CW'(1);
            end
          end
        end
        default: state <= S_WAIT;
      endcase

      cap <= cap_nxt;
      if (accept) begin
        fbuf[idx] <= dec[3:0];
        ebuf[idx] <= dec[4];
        tcnt      <= '0;
        stalled   <= 1'b0;
      end else if (tcnt != TIMEOUT_MAX) begin
        tcnt <= tcnt + TW'(1);
      end
      if (timeout_hit) stalled <= 1'b1;

      if (done) begin
        value       <= {fbuf[3], fbuf[2], fbuf[1], fbuf[0]};
        err_mask    <= ebuf;
        frame_err   <= |ebuf;
        frame_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench for sevenseg_scan_decoder: scans, glitches, illegal digits,
// invalid anode patterns, timeout, mid-frame reset and the settle boundary.
module tb_sevenseg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  err_mask;
  logic        stalled;

  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  int base;
  logic [15:0] fv_value;
  logic        fv_err;
  logic [3:0]  fv_mask;

  sevenseg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .value(value),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_mask(err_mask),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  // Latch what each frame strobe reported.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt   <= fv_cnt + 1;
      fv_value <= value;
      fv_err   <= frame_err;
      fv_mask  <= err_mask;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h7E; 4'h1: p = 7'h30; 4'h2: p = 7'h6D; 4'h3: p = 7'h79;
      4'h4: p = 7'h33; 4'h5: p = 7'h5B; 4'h6: p = 7'h5F; 4'h7: p = 7'h70;
      4'h8: p = 7'h7F; 4'h9: p = 7'h7B; 4'hA: p = 7'h77; 4'hB: p = 7'h1F;
      4'hC: p = 7'h4E; 4'hD: p = 7'h3D; 4'hE: p = 7'h4F; default: p = 7'h47;
    endcase
    return ~p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dig_raw(input int i, input logic [6:0] s, input int n);
    logic [3:0] one;
    one = 4'b0001;
    drive(~(one << i), s, n);
  endtask

  task automatic dig(input int i, input logic [3:0] d, input int n);
    dig_raw(i, seg_of(d), n);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_mask", 32'(err_mask), 32'h0);
    chk("rst_stalled", 32'(stalled), 32'h0);
    reset = 1'b0;
    idle(2);

    // Basic scan 4,3,2,1 on digits 0..3
    base = fv_cnt;
    dig(0, 4'h4, 8); dig(1, 4'h3, 8); dig(2, 4'h2, 8); dig(3, 4'h1, 8);
    idle(4);
    chk("scan_frames", 32'(fv_cnt - base), 32'd1);
    chk("scan_value", 32'(fv_value), 32'h1234);
    chk("scan_ferr", 32'(fv_err), 32'h0);
    chk("scan_mask", 32'(fv_mask), 32'h0);

    // Two-clock glitch on digit 0 before a stable 5
    base = fv_cnt;
    dig_raw(0, 7'h00, 2);
    chk("glitch_noframe", 32'(fv_cnt - base), 32'd0);
    dig(0, 4'h5, 8); dig(1, 4'h6, 8); dig(2, 4'h7, 8); dig(3, 4'h8, 8);
    idle(4);
    chk("glitch_frames", 32'(fv_cnt - base), 32'd1);
    chk("glitch_value", 32'(fv_value), 32'h8765);

    // Illegal pattern on digit 2
    base = fv_cnt;
    dig(0, 4'hA, 8); dig(1, 4'hB, 8); dig_raw(2, ~7'h01, 8); dig(3, 4'hC, 8);
    idle(4);
    chk("illegal_frames", 32'(fv_cnt - base), 32'd1);
    chk("illegal_value", 32'(fv_value), 32'hC0BA);
    chk("illegal_mask", 32'(fv_mask), 32'h4);
    chk("illegal_ferr", 32'(fv_err), 32'h1);

    // Invalid anode patterns leave the partial capture intact
    base = fv_cnt;
    dig(0, 4'h1, 8); dig(1, 4'h2, 8); dig(2, 4'h3, 8);
    drive(4'hC, seg_of(4'h9), 20);
    idle(20);
    chk("invalid_an_noframe", 32'(fv_cnt - base), 32'd0);
    dig(3, 4'h4, 8);
    idle(4);
    chk("invalid_an_frames", 32'(fv_cnt - base), 32'd1);
    chk("invalid_an_value", 32'(fv_value), 32'h4321);

    // Timeout drops digits 0,1 and raises stalled
    dig(0, 4'hA, 8); dig(1, 4'hB, 8);
    idle(50);
    chk("pre_timeout_stalled", 32'(stalled), 32'h0);
    idle(20);
    chk("timeout_stalled", 32'(stalled), 32'h1);
    chk("timeout_value", 32'(value), 32'h4321);
    base = fv_cnt;
    dig(0, 4'h9, 8);
    chk("stall_clear", 32'(stalled), 32'h0);
    dig(1, 4'h8, 8); dig(2, 4'h7, 8);
    chk("timeout_dropped", 32'(fv_cnt - base), 32'd0);
    dig(3, 4'h6, 8);
    idle(4);
    chk("timeout_frames", 32'(fv_cnt - base), 32'd1);
    chk("timeout_value2", 32'(fv_value), 32'h6789);

    // Reset after three accepted digits discards them
    dig(0, 4'h3, 8); dig(1, 4'h3, 8); dig(2, 4'h3, 8);
    an    = 4'hF;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_value", 32'(value), 32'h0);
    chk("mid_rst_mask", 32'(err_mask), 32'h0);
    chk("mid_rst_stalled", 32'(stalled), 32'h0);
    base = fv_cnt;
    dig(3, 4'hD, 8);
    idle(3);
    chk("mid_rst_noframe", 32'(fv_cnt - base), 32'd0);
    chk("mid_rst_value2", 32'(value), 32'h0);
    dig(0, 4'hA, 8); dig(1, 4'hB, 8); dig(2, 4'hC, 8);
    idle(4);
    chk("mid_rst_frames", 32'(fv_cnt - base), 32'd1);
    chk("mid_rst_value3", 32'(fv_value), 32'hDCBA);

    // Settle boundary, overwrite of a repeated digit, one-clock latency
    base = fv_cnt;
    dig(0, 4'h5, 8); dig(0, 4'h1, 4); dig(1, 4'h6, 4); dig(2, 4'h7, 4);
    dig(3, 4'h8, 3);
    idle(5);
    chk("settle_short_noframe", 32'(fv_cnt - base), 32'd0);
    dig(3, 4'h8, 4);
    an = 4'hF;
    @(posedge clk); #1;
    chk("latency_accept_edge", 32'(frame_valid), 32'h0);
    @(posedge clk); #1;
    chk("latency_pulse", 32'(frame_valid), 32'h1);
    chk("settle_value", 32'(value), 32'h8761);
    @(posedge clk); #1;
    chk("pulse_width", 32'(frame_valid), 32'h0);
    idle(4);
    chk("settle_frames", 32'(fv_cnt - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
